// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC owner, single-outstanding imem handshake, redirect squash
module if_stage #(
    parameter logic [63:0] RESET_PC      = 64'h0000_0000_8000_0000,
    parameter int          FETCH_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_redirect_ena,
    input  logic [63:0] pc_redirect_addr,
    input  logic        stall,
    output logic        if_valid,
    output logic [63:0] if_addr,
    input  logic        if_ready,
    input  logic        if_rvalid,
    input  logic [31:0] if_rdata,
    output logic [31:0] inst,
    output logic        inst_ready,
    output logic [63:0] pc,
    output logic        fetch_err
);

    localparam int          TW      = $clog2(FETCH_TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic          inst_ready_q, inst_ready_d;
    logic          fetch_err_q, fetch_err_d;
    logic          drop_q, drop_d;
    logic [63:0]   pend_q, pend_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [63:0]   tgt;

    assign tgt        = pc_redirect_addr & ~64'h3;
    assign if_valid   = (state_q == S_REQ);
    assign if_addr    = pc_q;
    assign inst       = inst_q;
    assign inst_ready = inst_ready_q;
    assign pc         = pc_q;
    assign fetch_err  = fetch_err_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_ready_d = inst_ready_q;
        fetch_err_d  = fetch_err_q;
        drop_d       = drop_q;
        pend_d       = pend_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            S_REQ: begin
                if (if_ready) begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = '0;
                    if (pc_redirect_ena) begin
                        drop_d = 1'b1;
                        pend_d = tgt;
                    end
                end else if (pc_redirect_ena) begin
                    pc_d = tgt;
                end
            end
            S_WAIT: begin
                if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (if_rvalid) begin
                    // A redirect arriving with the response wins over both data and any pending target
                    if (pc_redirect_ena) begin
                        pc_d    = tgt;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (drop_q) begin
                        pc_d    = pend_q;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d       = if_rdata;
                        inst_ready_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else begin
                    if (tmo_cnt_q == TMO_MAX) fetch_err_d = 1'b1;
                    if (pc_redirect_ena) begin
                        drop_d = 1'b1;
                        pend_d = tgt;
                    end
                end
            end
            S_HOLD: begin
                if (pc_redirect_ena) begin
                    inst_ready_d = 1'b0;
                    pc_d         = tgt;
                    state_d      = S_REQ;
                end else if (!stall) begin
                    inst_ready_d = 1'b0;
                    pc_d         = pc_q + 64'd4;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_ready_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            drop_q       <= 1'b0;
            pend_q       <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_ready_q <= inst_ready_d;
            fetch_err_q  <= fetch_err_d;
            drop_q       <= drop_d;
            pend_q       <= pend_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        pc_redirect_ena;
    logic [63:0] pc_redirect_addr;
    logic        stall;
    logic        if_valid;
    logic [63:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] inst;
    logic        inst_ready;
    logic [63:0] pc;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [63:0] addr;
        int          stall_n;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];

    if_stage #(.RESET_PC(RPC), .FETCH_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .pc_redirect_ena(pc_redirect_ena), .pc_redirect_addr(pc_redirect_addr),
        .stall(stall),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .inst(inst), .inst_ready(inst_ready), .pc(pc), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rst && if_valid && if_ready) acc_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int stall_n);
        exp_t e;
        exp_t g;
        int n;
        n = 0;
        while (!if_valid && n < 20) begin step(); n++; end
        chk("req_seen", 64'(if_valid), 64'd1);
        chk("if_addr", if_addr, addr);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        chk("valid_drop_after_accept", 64'(if_valid), 64'd0);
        if_rvalid = 1'b1;
        if_rdata  = data;
        e.inst = data;
        e.pc   = addr;
        sb.push_back(e);
        step();
        if_rvalid = 1'b0;
        n = 0;
        while (!inst_ready && n < 10) begin step(); n++; end
        chk("inst_ready_latency", 64'(n), 64'd0);
        chk("inst_ready", 64'(inst_ready), 64'd1);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            chk("inst", 64'(inst), 64'(g.inst));
            chk("pc", pc, g.pc);
        end else begin
            g = e;
        end
        stall = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            step();
            chk("stall_inst_ready", 64'(inst_ready), 64'd1);
            chk("stall_inst", 64'(inst), 64'(g.inst));
            chk("stall_pc", pc, g.pc);
            chk("stall_no_req", 64'(if_valid), 64'd0);
        end
        stall = 1'b0;
        step();
        chk("inst_ready_clear", 64'(inst_ready), 64'd0);
    endtask

    task automatic accept_only();
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
    endtask

    initial begin
        int acc0;
        vecs[0] = '{32'h0000_0513, 64'h0000_0000_8000_0000, 0};
        vecs[1] = '{32'h0010_0593, 64'h0000_0000_8000_0004, 0};
        vecs[2] = '{32'h00b5_0633, 64'h0000_0000_8000_0008, 5};
        vecs[3] = '{32'h0006_0693, 64'h0000_0000_8000_000C, 0};

        rst = 1'b0; pc_redirect_ena = 1'b0; pc_redirect_addr = '0; stall = 1'b0;
        if_ready = 1'b0; if_rvalid = 1'b0; if_rdata = '0;
        step(); step();
        chk("rst_if_valid", 64'(if_valid), 64'd1);
        chk("rst_if_addr", if_addr, RPC);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_ready", 64'(inst_ready), 64'd0);
        chk("rst_fetch_err", 64'(fetch_err), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) fetch(vecs[i].addr, vecs[i].rdata, vecs[i].stall_n);

        // Redirect during WAIT: returned word dropped
        accept_only();
        pc_redirect_ena = 1'b1; pc_redirect_addr = 64'h0000_0000_8000_0103;
        step();
        pc_redirect_ena = 1'b0;
        if_rvalid = 1'b1; if_rdata = 32'hDEAD_BEEF;
        step();
        if_rvalid = 1'b0;
        chk("drop_inst_ready", 64'(inst_ready), 64'd0);
        chk("drop_if_valid", 64'(if_valid), 64'd1);
        chk("drop_if_addr", if_addr, 64'h0000_0000_8000_0100);
        fetch(64'h0000_0000_8000_0100, 32'h1234_5678, 0);

        // Redirect together with response
        accept_only();
        pc_redirect_ena = 1'b1; pc_redirect_addr = 64'h0000_0000_8000_0180;
        if_rvalid = 1'b1; if_rdata = 32'hBAD0_BAD0;
        step();
        pc_redirect_ena = 1'b0; if_rvalid = 1'b0;
        chk("redir_rvalid_inst_ready", 64'(inst_ready), 64'd0);
        chk("redir_rvalid_if_addr", if_addr, 64'h0000_0000_8000_0180);

        // Redirect in HOLD under stall
        accept_only();
        if_rvalid = 1'b1; if_rdata = 32'h0000_0013;
        step();
        if_rvalid = 1'b0;
        chk("hold_inst_ready", 64'(inst_ready), 64'd1);
        stall = 1'b1; pc_redirect_ena = 1'b1; pc_redirect_addr = 64'h0000_0000_8000_0200;
        step();
        stall = 1'b0;
        chk("hold_redir_inst_ready", 64'(inst_ready), 64'd0);
        chk("hold_redir_if_addr", if_addr, 64'h0000_0000_8000_0200);
        // Redirect in REQ while not accepted
        pc_redirect_addr = 64'h0000_0000_8000_0300;
        step();
        pc_redirect_ena = 1'b0;
        chk("req_redir_if_addr", if_addr, 64'h0000_0000_8000_0300);
        acc0 = acc_cnt;
        fetch(64'h0000_0000_8000_0300, 32'h0030_0713, 0);
        chk("one_request", 64'(acc_cnt - acc0), 64'd1);

        // pc+4 wraps to zero
        pc_redirect_ena = 1'b1; pc_redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        pc_redirect_ena = 1'b0;
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0793, 0);
        fetch(64'h0, 32'h0050_0813, 0);

        // Timeout with FETCH_TIMEOUT=8
        accept_only();
        for (int i = 0; i < 7; i++) step();
        chk("tmo_not_yet", 64'(fetch_err), 64'd0);
        step();
        chk("tmo_set", 64'(fetch_err), 64'd1);
        if_rvalid = 1'b1; if_rdata = 32'h0060_0893;
        step();
        if_rvalid = 1'b0;
        chk("late_rvalid_inst_ready", 64'(inst_ready), 64'd1);
        chk("late_rvalid_inst", 64'(inst), 64'h0060_0893);
        step();
        chk("tmo_sticky", 64'(fetch_err), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_clears_err", 64'(fetch_err), 64'd0);
        chk("rst_pc", pc, RPC);

        // Reset mid-transaction, late rvalid in REQ ignored
        accept_only();
        rst = 1'b0;
        step();
        rst = 1'b1;
        if_rvalid = 1'b1; if_rdata = 32'hFFFF_FFFF;
        step();
        if_rvalid = 1'b0;
        chk("late_after_rst_inst_ready", 64'(inst_ready), 64'd0);
        chk("late_after_rst_if_addr", if_addr, RPC);
        fetch(RPC, 32'h0070_0913, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
